// File: rtl/iguana_pkg.sv
// Shared types, register map and reset values for the Hyperbus configuration register block.
// Holds the Regbus request/response structs, the active PHY configuration and the reset helper.
package iguana_pkg;

  localparam int HypNumChips     = 2;
  localparam int HypMaxChips     = 2;
  localparam int HypRstChipBytes = 8 * 1024;

  // Regbus request/response, laid out as the Cheshire typedef macros produce them.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef struct packed {
    logic [3:0]                        lat;
    logic                              addlat;
    logic [15:0]                       csmax;
    logic [3:0]                        rwr;
    logic [HypMaxChips-1:0][31:0]      start_addr;
    logic [HypMaxChips-1:0][31:0]      end_addr;
  } hyper_cfg_t;

  typedef enum logic { RspIdle, RspResp } rsp_state_e;
  typedef enum logic { CommitIdle, CommitPending } commit_state_e;

  localparam logic [5:0] OffLat      = 6'h00;
  localparam logic [5:0] OffAddlat   = 6'h04;
  localparam logic [5:0] OffCsmax    = 6'h08;
  localparam logic [5:0] OffRwr      = 6'h0C;
  localparam logic [5:0] OffRuleBase = 6'h10;
  localparam logic [5:0] OffCommit   = 6'h20;
  localparam logic [5:0] OffStatus   = 6'h24;

  localparam logic [3:0]  RstLat    = 4'd6;
  localparam logic        RstAddlat = 1'b1;
  localparam logic [15:0] RstCsmax  = 16'd665;
  localparam logic [3:0]  RstRwr    = 4'd6;

  function automatic hyper_cfg_t hyp_rst_cfg(input int unsigned chip_bytes);
    hyper_cfg_t c;
    c        = '0;
    c.lat    = RstLat;
    c.addlat = RstAddlat;
    c.csmax  = RstCsmax;
    c.rwr    = RstRwr;
    for (int i = 0; i < HypMaxChips; i++) begin
      c.start_addr[i] = 32'(unsigned'(i) * chip_bytes);
      c.end_addr[i]   = 32'(unsigned'(i + 1) * chip_bytes);
    end
    return c;
  endfunction

  // Byte lanes with a set strobe take the new data, the rest keep the old value.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/iguana_hyper_cfg_commit.sv
// Commit FSM: waits for an idle PHY, then copies the staged configuration to the active one.
// The update pulse is registered so it is high in the first cycle cfg_o shows the new value.
module iguana_hyper_cfg_commit import iguana_pkg::*; #(
  parameter hyper_cfg_t RstCfg = hyp_rst_cfg(HypRstChipBytes)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       commit_req_i,
  input  logic       phy_idle_i,
  input  hyper_cfg_t shadow_i,
  output hyper_cfg_t cfg_o,
  output logic       cfg_update_o,
  output logic       pending_o
);

  commit_state_e state_q, state_d;
  hyper_cfg_t    cfg_q;
  logic          update_q;
  logic          load;

  // NOTE: every output of a combinational block gets a default before any branch;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      CommitIdle:    if (commit_req_i) state_d = CommitPending;
      CommitPending: if (phy_idle_i) begin
        load    = 1'b1;
        state_d = CommitIdle;
      end
      default:       state_d = CommitIdle;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= CommitIdle;
      cfg_q    <= RstCfg;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      update_q <= load;
      if (load) cfg_q <= shadow_i;
    end
  end

  assign cfg_o        = cfg_q;
  assign cfg_update_o = update_q;
  assign pending_o    = (state_q == CommitPending);

endmodule

// File: rtl/iguana_hyper_cfg_regs.sv
// Regbus register file holding a staged Hyperbus configuration plus a commit/status interface.
// Accesses are decoded and applied in the accepting cycle; the response is held for one RESP cycle.
module iguana_hyper_cfg_regs import iguana_pkg::*; #(
  parameter int unsigned NumChips     = HypNumChips,
  parameter int unsigned RstChipBytes = HypRstChipBytes
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  reg_req_t   reg_req_i,
  output reg_rsp_t   reg_rsp_o,
  input  logic       phy_idle_i,
  output hyper_cfg_t cfg_o,
  output logic       cfg_update_o
);

  localparam hyper_cfg_t RstCfg = hyp_rst_cfg(RstChipBytes);

  rsp_state_e  rsp_state_q, rsp_state_d;
  logic [31:0] rdata_q;
  logic        error_q;
  hyper_cfg_t  shadow_q, shadow_d;
  logic        commit_req;
  logic        pending;
  logic        accept;
  logic        hit;
  logic [31:0] rd_val;
  logic [31:0] wr_val;
  logic [5:0]  offset;
  logic        unused_addr;

  assign offset      = reg_req_i.addr[5:0];
  assign unused_addr = ^reg_req_i.addr[31:6];
  assign accept      = (rsp_state_q == RspIdle) && reg_req_i.valid;
  assign wr_val      = apply_strb(rd_val, reg_req_i.wdata, reg_req_i.wstrb);

  // Read mux doubles as the address decoder; rd_val is the current staged value for config regs.
  always_comb begin
    hit    = 1'b1;
    rd_val = '0;
    if (offset[1:0] != 2'b00) begin
      hit = 1'b0;
    end else begin
      case (offset)
        OffLat:    rd_val = {28'b0, shadow_q.lat};
        OffAddlat: rd_val = {31'b0, shadow_q.addlat};
        OffCsmax:  rd_val = {16'b0, shadow_q.csmax};
        OffRwr:    rd_val = {28'b0, shadow_q.rwr};
        OffCommit: rd_val = {31'b0, pending};
        OffStatus: rd_val = {30'b0, phy_idle_i, pending};
        default: begin
          hit = 1'b0;
          for (int i = 0; i < int'(NumChips) && i < HypMaxChips; i++) begin
            if (offset == 6'(OffRuleBase + 6'(8 * i))) begin
              hit    = 1'b1;
              rd_val = shadow_q.start_addr[i];
            end
            if (offset == 6'(OffRuleBase + 6'(8 * i + 4))) begin
              hit    = 1'b1;
              rd_val = shadow_q.end_addr[i];
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    shadow_d   = shadow_q;
    commit_req = 1'b0;
    if (accept && hit && reg_req_i.write) begin
      case (offset)
        OffLat:    shadow_d.lat    = wr_val[3:0];
        OffAddlat: shadow_d.addlat = wr_val[0];
        OffCsmax:  shadow_d.csmax  = wr_val[15:0];
        OffRwr:    shadow_d.rwr    = wr_val[3:0];
        OffCommit: commit_req      = reg_req_i.wdata[0] & reg_req_i.wstrb[0];
        OffStatus: ;
        default: begin
          for (int i = 0; i < int'(NumChips) && i < HypMaxChips; i++) begin
            if (offset == 6'(OffRuleBase + 6'(8 * i)))     shadow_d.start_addr[i] = wr_val;
            if (offset == 6'(OffRuleBase + 6'(8 * i + 4))) shadow_d.end_addr[i]   = wr_val;
          end
        end
      endcase
    end
  end

  always_comb begin
    rsp_state_d = rsp_state_q;
    case (rsp_state_q)
      RspIdle: if (reg_req_i.valid) rsp_state_d = RspResp;
      RspResp: rsp_state_d = RspIdle;
      default: rsp_state_d = RspIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_state_q <= RspIdle;
      rdata_q     <= '0;
      error_q     <= 1'b0;
      shadow_q    <= RstCfg;
    end else begin
      rsp_state_q <= rsp_state_d;
      shadow_q    <= shadow_d;
      if (accept) begin
        rdata_q <= hit ? rd_val : 32'h0;
        error_q <= ~hit;
      end
    end
  end

  assign reg_rsp_o.rdata = rdata_q;
  assign reg_rsp_o.error = error_q;
  assign reg_rsp_o.ready = (rsp_state_q == RspResp);

  // A shadow write landing on the commit edge is seen by the copy as its pre-edge value.
  iguana_hyper_cfg_commit #(
    .RstCfg (RstCfg)
  ) u_commit (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .commit_req_i (commit_req),
    .phy_idle_i   (phy_idle_i),
    .shadow_i     (shadow_q),
    .cfg_o        (cfg_o),
    .cfg_update_o (cfg_update_o),
    .pending_o    (pending)
  );

endmodule
